resp_router_buf: RTL and testbench

Buffered response router for the peripheral interconnect. Takes the single response stream returned by a peripheral/test-and-set port, decodes the one-hot master ID, and pushes each beat into a per-master response FIFO with its own valid/ready handshake toward the master. Successor to the purely combinational response decoder: adds data/opcode routing, per-master buffering, upstream backpressure and illegal-ID detection.

---
 rtl/resp_router_buf.sv | 137 +++++++++++++
 tb/tb_resp_router_buf.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_router_buf.sv
`default_nettype none
// ============================================================================
// resp_router_buf : one-hot response router with a small FIFO per master
// Optional macro RESP_ID_CHECK_EN : drop illegal IDs and count them
// Revision : 1.0
// ============================================================================
module resp_router_buf #(
   parameter int ID_WIDTH   = 20,
   parameter int N_MASTER   = 20,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           data_r_valid_i,
   output logic                           data_r_ready_o,
   input  logic [ID_WIDTH-1:0]            data_ID_i,
   input  logic [DATA_WIDTH-1:0]          data_r_rdata_i,
   input  logic                           data_r_opc_i,
   output logic [N_MASTER-1:0]            data_r_valid_o,
   input  logic [N_MASTER-1:0]            data_r_ready_i,
   output logic [N_MASTER*DATA_WIDTH-1:0] data_r_rdata_o,
   output logic [N_MASTER-1:0]            data_r_opc_o,
   output logic                           err_o,
   output logic [7:0]                     err_cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = DATA_WIDTH + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [EW-1:0]       mem_q    [N_MASTER][DEPTH];
   logic [EW-1:0]       mem_d    [N_MASTER][DEPTH];
   logic [PW-1:0]       wr_ptr_q [N_MASTER];
   logic [PW-1:0]       wr_ptr_d [N_MASTER];
   logic [PW-1:0]       rd_ptr_q [N_MASTER];
   logic [PW-1:0]       rd_ptr_d [N_MASTER];
   logic [CW-1:0]       cnt_q    [N_MASTER];
   logic [CW-1:0]       cnt_d    [N_MASTER];
   logic [N_MASTER-1:0] tgt;
   logic [N_MASTER-1:0] full;
   logic [N_MASTER-1:0] push;
   logic [N_MASTER-1:0] pop;
   logic                drop_id;
   logic                accept;

   assign tgt = data_ID_i;

`ifdef RESP_ID_CHECK_EN
   logic       err_q;
   logic       err_d;
   logic [7:0] err_cnt_q;
   logic [7:0] err_cnt_d;

   // Zero or multi-hot IDs are swallowed without touching any FIFO
   assign drop_id   = (tgt == '0) || ((tgt & (tgt - N_MASTER'(1))) != '0);
   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;

   always_comb begin
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      if (accept && drop_id) begin
         err_d = 1'b1;
         if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q     <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end
`else
   assign drop_id   = 1'b0;
   assign err_o     = 1'b0;
   assign err_cnt_o = 8'd0;
`endif

   // Ready looks only at full flags, so a popping full FIFO still refuses a push
   assign data_r_ready_o = drop_id | ~|(tgt & full);
   assign accept         = data_r_valid_i & data_r_ready_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      full     = '0;
      push     = '0;
      pop      = '0;
      for (int k = 0; k < N_MASTER; k++) begin
         full[k] = (cnt_q[k] == FULL_CNT);
         push[k] = accept & tgt[k] & ~drop_id;
         pop[k]  = (cnt_q[k] != '0) & data_r_ready_i[k];
         if (push[k]) begin
            mem_d[k][wr_ptr_q[k]] = {data_r_rdata_i, data_r_opc_i};
            wr_ptr_d[k]           = wr_ptr_q[k] + PW'(1);
         end
         if (pop[k]) rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
         case ({push[k], pop[k]})
            2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
            2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
            default: cnt_d[k] = cnt_q[k];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_MASTER; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            cnt_q[k]    <= '0;
            for (int e = 0; e < DEPTH; e++) mem_q[k][e] <= '0;
         end
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   for (genvar k = 0; k < N_MASTER; k++) begin : g_out
      assign data_r_valid_o[k]                          = (cnt_q[k] != '0);
      assign data_r_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k][rd_ptr_q[k]][EW-1:1];
      assign data_r_opc_o[k]                            = mem_q[k][rd_ptr_q[k]][0];
   end

endmodule
`default_nettype wire

// File: tb/tb_resp_router_buf.sv
`default_nettype none
// ============================================================================
// tb_resp_router_buf : scoreboard bench for resp_router_buf
// Revision : 1.0
// ============================================================================
module tb_resp_router_buf;

   localparam int NM = 20;
   localparam int DW = 32;
   localparam int DP = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             data_r_valid_i;
   logic             data_r_ready_o;
   logic [NM-1:0]    data_ID_i;
   logic [DW-1:0]    data_r_rdata_i;
   logic             data_r_opc_i;
   logic [NM-1:0]    data_r_valid_o;
   logic [NM-1:0]    data_r_ready_i;
   logic [NM*DW-1:0] data_r_rdata_o;
   logic [NM-1:0]    data_r_opc_o;
   logic             err_o;
   logic [7:0]       err_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW:0] sb_q [NM][$];
   logic        exp_err = 1'b0;
   logic [7:0]  exp_err_cnt = 8'd0;

   always #5 clk = ~clk;

   resp_router_buf #(.ID_WIDTH(NM), .N_MASTER(NM), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_r_valid_i (data_r_valid_i),
      .data_r_ready_o (data_r_ready_o),
      .data_ID_i      (data_ID_i),
      .data_r_rdata_i (data_r_rdata_i),
      .data_r_opc_i   (data_r_opc_i),
      .data_r_valid_o (data_r_valid_o),
      .data_r_ready_i (data_r_ready_i),
      .data_r_rdata_o (data_r_rdata_o),
      .data_r_opc_o   (data_r_opc_o),
      .err_o          (err_o),
      .err_cnt_o      (err_cnt_o)
   );

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Model of the router: queue sizes stand in for FIFO occupancy
   always @(negedge clk) begin : monitor
      logic [NM-1:0] exp_v;
      logic [NM-1:0] exp_full;
      logic          legal;
      logic          exp_rdy;
      logic          chk_en;
`ifdef RESP_ID_CHECK_EN
      chk_en = 1'b1;
`else
      chk_en = 1'b0;
`endif
      if (rst) begin
         for (int k = 0; k < NM; k++) sb_q[k].delete();
         exp_err     = 1'b0;
         exp_err_cnt = 8'd0;
      end else begin
         for (int k = 0; k < NM; k++) begin
            exp_v[k]    = (sb_q[k].size() != 0);
            exp_full[k] = (sb_q[k].size() == DP);
         end
         legal   = $onehot(data_ID_i);
         exp_rdy = (chk_en && !legal) ? 1'b1 : ~|(data_ID_i & exp_full);
         check_val("valid_o", 64'(data_r_valid_o), 64'(exp_v));
         check_val("ready_o", 64'(data_r_ready_o), 64'(exp_rdy));
         check_val("err_o", 64'(err_o), 64'(exp_err));
         check_val("err_cnt", 64'(err_cnt_o), 64'(exp_err_cnt));
         for (int k = 0; k < NM; k++) begin
            if (exp_v[k] && data_r_ready_i[k]) begin
               check_val($sformatf("head_m%0d", k),
                         64'({data_r_rdata_o[k*DW +: DW], data_r_opc_o[k]}), 64'(sb_q[k][0]));
               void'(sb_q[k].pop_front());
            end
         end
         if (data_r_valid_i && exp_rdy) begin
            if (chk_en && !legal) begin
               exp_err = 1'b1;
               if (exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
            end else begin
               for (int k = 0; k < NM; k++)
                  if (data_ID_i[k]) sb_q[k].push_back({data_r_rdata_i, data_r_opc_i});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_beat(input logic [NM-1:0] id, input logic [DW-1:0] d, input logic opc);
      data_r_valid_i = 1'b1;
      data_ID_i      = id;
      data_r_rdata_i = d;
      data_r_opc_i   = opc;
   endtask

   // Holds the current beat until accepted; n = cycles spent
   task automatic wait_accept(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!data_r_ready_o && n < 100);
      check_val("accept_timeout", 64'(data_r_ready_o), 64'd1);
      tick();
      data_r_valid_i = 1'b0;
   endtask

   task automatic send(input logic [NM-1:0] id, input logic [DW-1:0] d, input logic opc);
      int n;
      start_beat(id, d, opc);
      wait_accept(n);
   endtask

   initial begin : stim
      int n;
      int acc;
      int left;
      rst            = 1'b1;
      data_r_valid_i = 1'b0;
      data_ID_i      = '0;
      data_r_rdata_i = '0;
      data_r_opc_i   = 1'b0;
      data_r_ready_i = '0;
      repeat (3) tick();
      rst = 1'b0;

      @(negedge clk);
      check_val("rst_valid", 64'(data_r_valid_o), 64'd0);
      check_val("rst_rdata", 64'(|data_r_rdata_o), 64'd0);
      check_val("rst_err", 64'({err_o, err_cnt_o}), 64'd0);
      tick();

      // Single beat to master 2, one cycle of valid
      data_r_ready_i = 20'h00004;
      send(20'h00004, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      check_val("t1_valid", 64'(data_r_valid_o), 64'h4);
      check_val("t1_data", 64'(data_r_rdata_o[2*DW +: DW]), 64'hDEADBEEF);
      tick();
      @(negedge clk);
      check_val("t1_gone", 64'(data_r_valid_o), 64'd0);
      tick();

      // Fill master 5, third beat must stall
      data_r_ready_i = '0;
      send(20'h00020, 32'hA1A1_0001, 1'b0);
      send(20'h00020, 32'hA2A2_0002, 1'b1);
      start_beat(20'h00020, 32'hA3A3_0003, 1'b0);
      @(negedge clk);
      check_val("t2_blocked", 64'(data_r_ready_o), 64'd0);
      tick();
      data_r_valid_i = 1'b0;

      // Other master unaffected by full master 5
      data_r_ready_i = 20'h00001;
      start_beat(20'h00001, 32'hB0B0_0001, 1'b1);
      wait_accept(n);
      check_val("t3_no_hol", 64'(n), 64'd1);

      // Full FIFO popping this cycle still rejects the push
      data_r_ready_i = 20'h00021;
      start_beat(20'h00020, 32'hA3A3_0003, 1'b0);
      @(negedge clk);
      check_val("t4_pop_rej", 64'(data_r_ready_o), 64'd0);
      tick();
      @(negedge clk);
      check_val("t4_next_acc", 64'(data_r_ready_o), 64'd1);
      tick();
      data_r_valid_i = 1'b0;
      repeat (4) tick();

      // Back-to-back stream at full rate
      data_r_ready_i = '1;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         start_beat(20'h00008, 32'h3000_0000 + i, i[0]);
         @(negedge clk);
         if (data_r_ready_o) acc++;
         tick();
      end
      data_r_valid_i = 1'b0;
      check_val("t5_rate", 64'(acc), 64'd10);
      repeat (3) tick();

`ifdef RESP_ID_CHECK_EN
      send(20'h00003, 32'hBAD0_0003, 1'b0);
      send(20'h00000, 32'hBAD0_0000, 1'b1);
      @(negedge clk);
      check_val("t6_err", 64'(err_o), 64'd1);
      check_val("t6_cnt", 64'(err_cnt_o), 64'd2);
      check_val("t6_novalid", 64'(data_r_valid_o), 64'd0);
      tick();
      start_beat(20'h00003, 32'h0, 1'b0);
      repeat (300) tick();
      data_r_valid_i = 1'b0;
      @(negedge clk);
      check_val("t6_sat", 64'(err_cnt_o), 64'd255);
      tick();
`else
      // Multi-hot broadcast to masters 0 and 1
      data_r_ready_i = '0;
      send(20'h00003, 32'hC0C0_1234, 1'b1);
      @(negedge clk);
      check_val("t6_bcast", 64'(data_r_valid_o), 64'h3);
      tick();
      data_r_ready_i = '1;
      repeat (2) tick();
      data_r_ready_i = '0;
      send(20'h00000, 32'hD0D0_0000, 1'b0);
      @(negedge clk);
      check_val("t6_zero_drop", 64'(data_r_valid_o), 64'd0);
      tick();
`endif

      // Reset with beats pending
      data_r_ready_i = '0;
      send(20'h00080, 32'hE0E0_0007, 1'b0);
      send(20'h00100, 32'hE0E0_0008, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_val("t7_rst_valid", 64'(data_r_valid_o), 64'd0);
      check_val("t7_rst_rdata", 64'(|data_r_rdata_o), 64'd0);
      tick();

      data_r_ready_i = '1;
      repeat (5) tick();
      left = 0;
      for (int k = 0; k < NM; k++) left += sb_q[k].size();
      check_val("drain", 64'(left), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
